// File: rtl/obi_mem_responder.sv
// rtl/obi_mem_responder.sv - OBI responder with word memory, grant wait states and fixed response latency
// Optional checker: define OBI_MEM_RESPONDER_PROTO_CHECK_EN to build the sticky request-stability flag.
package obi_mem_responder_pkg;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_mem_responder
  import obi_mem_responder_pkg::*;
#(
  parameter int unsigned NUM_WORDS  = 1024,
  parameter int unsigned GNT_WAIT   = 0,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  slave_req_i,
  output obi_resp_t slave_resp_o,
  output logic      proto_err_o
);
  localparam int unsigned AW = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GRANT} gnt_state_e;

  gnt_state_e    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          gnt;
  logic          hs;
  logic [AW-1:0] idx;
  logic          unused_addr_bits;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // With GNT_WAIT=0 the machine never leaves IDLE; gnt follows req directly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (slave_req_i.req && (GNT_WAIT != 0)) begin
          cnt_d   = 3'd1;
          state_d = (GNT_WAIT == 1) ? ST_GRANT : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!slave_req_i.req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_d == 3'(GNT_WAIT)) state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    gnt = rst_ni & slave_req_i.req & ((GNT_WAIT == 0) || (state_q == ST_GRANT));
  end

  assign hs  = slave_req_i.req & gnt;
  assign idx = slave_req_i.addr[AW+1:2];
  assign unused_addr_bits = ^{slave_req_i.addr[31:AW+2], slave_req_i.addr[1:0]};

  logic [31:0] mem [NUM_WORDS];

  always_ff @(posedge clk_i) begin
    if (hs && slave_req_i.we) begin
      for (int i = 0; i < 4; i++) begin
        if (slave_req_i.be[i]) mem[idx][8*i +: 8] <= slave_req_i.wdata[8*i +: 8];
      end
    end
  end

  logic [RD_LATENCY-1:0] pipe_valid;
  logic [RD_LATENCY-1:0] pipe_read;
  logic [31:0]           pipe_data [RD_LATENCY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_valid <= '0;
      pipe_read  <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_data[i] <= '0;
    end else begin
      pipe_valid[0] <= hs;
      pipe_read[0]  <= hs & ~slave_req_i.we;
      if (hs) pipe_data[0] <= mem[idx];
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_read[i]  <= pipe_read[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign slave_resp_o.gnt    = gnt;
  assign slave_resp_o.rvalid = pipe_valid[RD_LATENCY-1];
  assign slave_resp_o.rdata  = (pipe_valid[RD_LATENCY-1] && pipe_read[RD_LATENCY-1]) ?
                               pipe_data[RD_LATENCY-1] : '0;

`ifdef OBI_MEM_RESPONDER_PROTO_CHECK_EN
  logic        pend_q;
  logic        err_q;
  logic [68:0] fields_q;

  // A request left waiting must stay asserted and unchanged until granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      fields_q <= '0;
    end else begin
      pend_q <= slave_req_i.req & ~gnt;
      if (slave_req_i.req && !gnt) begin
        fields_q <= {slave_req_i.addr, slave_req_i.we, slave_req_i.be, slave_req_i.wdata};
      end
      if (pend_q && (!slave_req_i.req ||
          ({slave_req_i.addr, slave_req_i.we, slave_req_i.be, slave_req_i.wdata} != fields_q))) begin
        err_q <= 1'b1;
      end
    end
  end

  assign proto_err_o = err_q;
`else
  assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_obi_mem_responder.sv
// tb/tb_obi_mem_responder.sv - directed self-checking bench over four responder configurations
module tb_obi_mem_responder;
  import obi_mem_responder_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  obi_req_t  req_a, req_b, req_c, req_d;
  obi_resp_t resp_a, resp_b, resp_c, resp_d;
  logic      err_a, err_b, err_c, err_d;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef OBI_MEM_RESPONDER_PROTO_CHECK_EN
  localparam logic [31:0] EXP_ERR = 32'd1;
`else
  localparam logic [31:0] EXP_ERR = 32'd0;
`endif

  obi_mem_responder #(.NUM_WORDS(16), .GNT_WAIT(0), .RD_LATENCY(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .slave_req_i(req_a), .slave_resp_o(resp_a), .proto_err_o(err_a));
  obi_mem_responder #(.NUM_WORDS(1024), .GNT_WAIT(3), .RD_LATENCY(2)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .slave_req_i(req_b), .slave_resp_o(resp_b), .proto_err_o(err_b));
  obi_mem_responder #(.NUM_WORDS(1024), .GNT_WAIT(0), .RD_LATENCY(4)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .slave_req_i(req_c), .slave_resp_o(resp_c), .proto_err_o(err_c));
  obi_mem_responder #(.NUM_WORDS(1024), .GNT_WAIT(2), .RD_LATENCY(1)) u_d (
    .clk_i(clk), .rst_ni(rst_n), .slave_req_i(req_d), .slave_resp_o(resp_d), .proto_err_o(err_d));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic obi_req_t mk(input logic r, input logic [31:0] a, input logic w,
                                  input logic [3:0] b, input logic [31:0] d);
    return '{req: r, addr: a, we: w, be: b, wdata: d};
  endfunction

  obi_req_t    idle_req;
  obi_req_t    tab_a [10];
  logic [31:0] exp_a [10];

  initial begin
    idle_req = mk(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    rst_n = 1'b0;
    req_a = idle_req; req_b = idle_req; req_c = idle_req; req_d = idle_req;

    @(negedge clk); #1;
    check("rst_gnt",    32'(resp_a.gnt), 32'd0);
    check("rst_rvalid", 32'(resp_a.rvalid), 32'd0);
    check("rst_rdata",  resp_a.rdata, 32'd0);
    check("rst_err",    32'(err_d), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // A: full write/read, partial write, be=0 write, aliasing (NUM_WORDS=16)
    tab_a[0] = mk(1'b1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF); exp_a[0] = 32'h0;
    tab_a[1] = mk(1'b1, 32'h10, 1'b0, 4'hF, 32'h0);        exp_a[1] = 32'hDEADBEEF;
    tab_a[2] = mk(1'b1, 32'h20, 1'b1, 4'hF, 32'h11223344); exp_a[2] = 32'h0;
    tab_a[3] = mk(1'b1, 32'h20, 1'b1, 4'h5, 32'hAABBCCDD); exp_a[3] = 32'h0;
    tab_a[4] = mk(1'b1, 32'h20, 1'b0, 4'hF, 32'h0);        exp_a[4] = 32'h11BB33DD;
    tab_a[5] = mk(1'b1, 32'h20, 1'b1, 4'h0, 32'hFFFFFFFF); exp_a[5] = 32'h0;
    tab_a[6] = mk(1'b1, 32'h20, 1'b0, 4'hF, 32'h0);        exp_a[6] = 32'h11BB33DD;
    tab_a[7] = mk(1'b1, 32'h40, 1'b1, 4'hF, 32'h0000005A); exp_a[7] = 32'h0;
    tab_a[8] = mk(1'b1, 32'h00, 1'b0, 4'hF, 32'h0);        exp_a[8] = 32'h0000005A;
    tab_a[9] = mk(1'b1, 32'h10, 1'b0, 4'hF, 32'h0);        exp_a[9] = 32'hDEADBEEF;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("a_rvalid_%0d", i-1), 32'(resp_a.rvalid), 32'd1);
        check($sformatf("a_rdata_%0d", i-1), resp_a.rdata, exp_a[i-1]);
      end
      if (i < 10) begin
        req_a = tab_a[i];
        #1 check($sformatf("a_gnt_%0d", i), 32'(resp_a.gnt), 32'd1);
      end else begin
        req_a = idle_req;
      end
    end
    @(negedge clk);
    check("a_idle_rvalid", 32'(resp_a.rvalid), 32'd0);
    check("a_idle_rdata",  resp_a.rdata, 32'd0);

    // B: GNT_WAIT=3, RD_LATENCY=2, req held high across two transactions
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      check($sformatf("b_rvalid_c%0d", i), 32'(resp_b.rvalid), (i == 6 || i == 10) ? 32'd1 : 32'd0);
      check($sformatf("b_rdata_c%0d", i), resp_b.rdata, (i == 10) ? 32'h12345678 : 32'h0);
      if (i <= 4)      req_b = mk(1'b1, 32'h8, 1'b1, 4'hF, 32'h12345678);
      else if (i <= 8) req_b = mk(1'b1, 32'h8, 1'b0, 4'hF, 32'h0);
      else             req_b = idle_req;
      #1 check($sformatf("b_gnt_c%0d", i), 32'(resp_b.gnt), (i == 4 || i == 8) ? 32'd1 : 32'd0);
    end
    check("b_err", 32'(err_b), 32'd0);

    // C: GNT_WAIT=0, RD_LATENCY=4, preload then four back-to-back reads
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      req_c = mk(1'b1, 32'(4*w), 1'b1, 4'hF, 32'(w+1));
    end
    @(negedge clk); req_c = idle_req;
    repeat (4) @(negedge clk);
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      check($sformatf("c_rvalid_%0d", i), 32'(resp_c.rvalid), (i >= 4 && i < 8) ? 32'd1 : 32'd0);
      check($sformatf("c_rdata_%0d", i), resp_c.rdata, (i >= 4 && i < 8) ? 32'(i-3) : 32'h0);
      if (i < 4) begin
        req_c = mk(1'b1, 32'(4*i), 1'b0, 4'hF, 32'h0);
        #1 check($sformatf("c_gnt_%0d", i), 32'(resp_c.gnt), 32'd1);
      end else begin
        req_c = idle_req;
      end
    end
    check("c_err", 32'(err_c), 32'd0);
    check("a_err", 32'(err_a), 32'd0);

    // D: GNT_WAIT=2, req dropped while waiting
    @(negedge clk);
    req_d = mk(1'b1, 32'h0, 1'b1, 4'h0, 32'h0);
    #1 check("d_drop_gnt", 32'(resp_d.gnt), 32'd0);
    @(negedge clk);
    check("d_drop_err_pre", 32'(err_d), 32'd0);
    req_d = idle_req;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("d_drop_err_%0d", i), 32'(err_d), EXP_ERR);
    end

    // Reset with two reads outstanding in C and a request pending on A
    @(negedge clk); req_c = mk(1'b1, 32'h0, 1'b0, 4'hF, 32'h0);
    @(negedge clk); req_c = mk(1'b1, 32'h4, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    req_c = idle_req;
    req_a = mk(1'b1, 32'h10, 1'b0, 4'hF, 32'h0);
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("r_c_rvalid_%0d", i), 32'(resp_c.rvalid), 32'd0);
      check($sformatf("r_c_rdata_%0d", i),  resp_c.rdata, 32'd0);
      check($sformatf("r_a_gnt_%0d", i),    32'(resp_a.gnt), 32'd0);
      check($sformatf("r_a_rvalid_%0d", i), 32'(resp_a.rvalid), 32'd0);
      check($sformatf("r_d_err_%0d", i),    32'(err_d), 32'd0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    req_a = idle_req;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_c_rvalid_%0d", i), 32'(resp_c.rvalid), 32'd0);
    end

    // D: field change before grant
    @(negedge clk);
    req_d = mk(1'b1, 32'h0, 1'b1, 4'h0, 32'h0);
    #1 check("d_chg_gnt0", 32'(resp_d.gnt), 32'd0);
    @(negedge clk);
    check("d_chg_err_pre", 32'(err_d), 32'd0);
    req_d = mk(1'b1, 32'h4, 1'b1, 4'h0, 32'h0);
    #1 check("d_chg_gnt1", 32'(resp_d.gnt), 32'd0);
    @(negedge clk);
    check("d_chg_err", 32'(err_d), EXP_ERR);
    #1 check("d_chg_gnt2", 32'(resp_d.gnt), 32'd1);
    @(negedge clk);
    req_d = idle_req;
    check("d_chg_err_hold", 32'(err_d), EXP_ERR);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
